// File: rtl/dbus_rr_arbiter.sv
// dbus_rr_arbiter: N-master to 1-slave round-robin arbiter for the CPU data bus.
// The selected master is forwarded to the slave in the same cycle, with no added latency.
// While the slave stalls, the grant stays locked on the owner. Other requesters wait,
// and the round-robin pointer moves past the master that was served last.
module dbus_rr_arbiter #(
    parameter int unsigned N_MASTER = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TRANS_W  = 8,
    parameter int unsigned ID_W     = $clog2(N_MASTER)
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [N_MASTER-1:0]            m_read,
    input  logic [N_MASTER-1:0]            m_write,
    input  logic [N_MASTER-1:0]            m_invalidate,
    input  logic [N_MASTER-1:0]            m_invalidate_icache,
    input  logic [N_MASTER*ADDR_W-1:0]     m_address,
    input  logic [N_MASTER*DATA_W-1:0]     m_wrdata,
    input  logic [N_MASTER*DATA_W/8-1:0]   m_byteenable,
    input  logic [N_MASTER*TRANS_W-1:0]    m_trans_in,
    output logic [N_MASTER-1:0]            m_stall,
    output logic [DATA_W-1:0]              m_rddata,
    output logic [TRANS_W-1:0]             m_trans_out,

    output logic                           s_read,
    output logic                           s_write,
    output logic                           s_invalidate,
    output logic                           s_invalidate_icache,
    output logic [ADDR_W-1:0]              s_address,
    output logic [DATA_W-1:0]              s_wrdata,
    output logic [DATA_W/8-1:0]            s_byteenable,
    output logic [TRANS_W-1:0]             s_trans_in,
    output logic [ID_W-1:0]                s_id,
    input  logic                           s_stall,
    input  logic [DATA_W-1:0]              s_rddata,
    input  logic [TRANS_W-1:0]             s_trans_out,

    output logic                           err_abort
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_q,    rr_d;
    logic            err_q,   err_d;

    logic [N_MASTER-1:0] req;
    logic [ID_W-1:0]     winner;
    logic                any_req;
    int unsigned         scan_idx;

    logic [ID_W-1:0]     sel;
    logic                fwd;

    logic                sel_read, sel_write, sel_inv, sel_inv_ic;

    // Next round-robin position, wrapping by modulo so any N_MASTER works.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
        if (32'(id) == N_MASTER - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // A master requests when any of its operation bits is set.
    assign req = m_read | m_write | m_invalidate | m_invalidate_icache;

    // Slave read data and tag are broadcast to every master.
    assign m_rddata    = s_rddata;
    assign m_trans_out = s_trans_out;

    // Winner: the first requester found when scanning upward from rr_q.
    always_comb begin
        winner   = rr_q;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            scan_idx = 32'(rr_q) + 32'(k);
            if (scan_idx >= N_MASTER) begin
                scan_idx = scan_idx - N_MASTER;
            end
            if (!any_req && req[scan_idx]) begin
                any_req = 1'b1;
                winner  = ID_W'(scan_idx);
            end
        end
    end

    // State, owner, pointer and abort-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, plus the selection of the master driven to the slave.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        err_d   = 1'b0;
        sel     = rr_q;
        fwd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel = winner;
                    fwd = 1'b1;
                    if (s_stall) begin
                        owner_d = winner;
                        state_d = LOCK;
                    end else begin
                        rr_d = rr_next(winner);
                    end
                end
            end
            LOCK: begin
                sel = owner_q;
                if (req[owner_q]) begin
                    fwd = 1'b1;
                    if (!s_stall) begin
                        rr_d    = rr_next(owner_q);
                        state_d = IDLE;
                    end
                end else begin
                    // The owner dropped its request while locked. Abort the transfer and flag it.
                    rr_d    = rr_next(owner_q);
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload mux: route the selected master's operation bits and payload to the slave.
    always_comb begin
        sel_read            = 1'b0;
        sel_write           = 1'b0;
        sel_inv             = 1'b0;
        sel_inv_ic          = 1'b0;
        s_address           = '0;
        s_wrdata            = '0;
        s_byteenable        = '0;
        s_trans_in          = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (sel == ID_W'(i)) begin
                sel_read     = m_read[i];
                sel_write    = m_write[i];
                sel_inv      = m_invalidate[i];
                sel_inv_ic   = m_invalidate_icache[i];
                s_address    = m_address[i*ADDR_W +: ADDR_W];
                s_wrdata     = m_wrdata[i*DATA_W +: DATA_W];
                s_byteenable = m_byteenable[i*BE_W +: BE_W];
                s_trans_in   = m_trans_in[i*TRANS_W +: TRANS_W];
            end
        end
    end

    // Request strobes reach the slave only while a transfer is being forwarded.
    assign s_read              = fwd & sel_read;
    assign s_write             = fwd & sel_write;
    assign s_invalidate        = fwd & sel_inv;
    assign s_invalidate_icache = fwd & sel_inv_ic;
    assign s_id                = sel;
    assign err_abort           = err_q;

    // Every requester stalls, except the master being served in a cycle the slave accepts.
    always_comb begin
        m_stall = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            m_stall[i] = req[i] & ~(fwd & (sel == ID_W'(i)) & ~s_stall);
        end
    end

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Directed testbench for dbus_rr_arbiter. It uses a 2-master instance and a 3-master instance.
module tb_dbus_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // 2-master instance
    logic [1:0]   r2, w2, i2, ic2, st2;
    logic [63:0]  a2, wd2;
    logic [7:0]   be2;
    logic [15:0]  t2;
    logic [31:0]  md2, srd2;
    logic [7:0]   mt2, sto2, sti2, sbe_dummy;
    logic         sr2, sw2, si2, sic2, ss2, err2;
    logic [31:0]  sa2, swd2;
    logic [3:0]   sbe2;
    logic [0:0]   sid2;

    dbus_rr_arbiter #(.N_MASTER(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .m_read(r2), .m_write(w2), .m_invalidate(i2), .m_invalidate_icache(ic2),
        .m_address(a2), .m_wrdata(wd2), .m_byteenable(be2), .m_trans_in(t2),
        .m_stall(st2), .m_rddata(md2), .m_trans_out(mt2),
        .s_read(sr2), .s_write(sw2), .s_invalidate(si2), .s_invalidate_icache(sic2),
        .s_address(sa2), .s_wrdata(swd2), .s_byteenable(sbe2), .s_trans_in(sti2),
        .s_id(sid2), .s_stall(ss2), .s_rddata(srd2), .s_trans_out(sto2),
        .err_abort(err2)
    );

    // 3-master instance
    logic [2:0]   r3, st3;
    logic [95:0]  a3, wd3;
    logic [11:0]  be3;
    logic [23:0]  t3;
    logic [31:0]  md3, sa3, swd3;
    logic [7:0]   mt3, sti3;
    logic         sr3, sw3, si3, sic3, err3;
    logic [3:0]   sbe3;
    logic [1:0]   sid3;

    dbus_rr_arbiter #(.N_MASTER(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .m_read(r3), .m_write(3'b000), .m_invalidate(3'b000), .m_invalidate_icache(3'b000),
        .m_address(a3), .m_wrdata(wd3), .m_byteenable(be3), .m_trans_in(t3),
        .m_stall(st3), .m_rddata(md3), .m_trans_out(mt3),
        .s_read(sr3), .s_write(sw3), .s_invalidate(si3), .s_invalidate_icache(sic3),
        .s_address(sa3), .s_wrdata(swd3), .s_byteenable(sbe3), .s_trans_in(sti3),
        .s_id(sid3), .s_stall(1'b0), .s_rddata(32'h0), .s_trans_out(8'h00),
        .err_abort(err3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the combinational outputs settle before sampling them.
    task automatic settle();
        #1;
    endtask

    initial begin
        sbe_dummy = '0;
        rst = 1'b1;
        r2 = '0; w2 = '0; i2 = '0; ic2 = '0;
        a2 = '0; wd2 = '0; be2 = '0; t2 = '0;
        ss2 = 1'b0; srd2 = '0; sto2 = '0;
        r3 = '0; a3 = '0; wd3 = '0; be3 = '0; t3 = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_s_read",  64'(sr2),  64'd0);
        check("rst_s_id",    64'(sid2), 64'd0);
        check("rst_err",     64'(err2), 64'd0);
        check("rst_m_stall", 64'(st2),  64'd0);
        tick();

        // 1: a lone m0 read is forwarded in the same cycle
        r2 = 2'b01; a2[31:0] = 32'h100;
        settle();
        check("t1_s_read",  64'(sr2),  64'd1);
        check("t1_s_id",    64'(sid2), 64'd0);
        check("t1_addr",    64'(sa2),  64'h100);
        check("t1_m_stall", 64'(st2),  64'd0);
        tick();
        r2 = 2'b00;
        settle();
        check("t1_rr_ptr",  64'(sid2), 64'd1);
        check("t1_idle_rd", 64'(sr2),  64'd0);
        tick();

        // 2: both masters read and the slave stalls for 3 cycles. m1 holds the lock, then m0 is served.
        r2 = 2'b11; a2 = {32'h200, 32'h100}; ss2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("t2_lock_id",    64'(sid2), 64'd1);
            check("t2_lock_stall", 64'(st2),  64'd3);
            tick();
        end
        ss2 = 1'b0;
        settle();
        check("t2_done_id",    64'(sid2), 64'd1);
        check("t2_done_stall", 64'(st2),  64'd1);
        check("t2_done_addr",  64'(sa2),  64'h200);
        tick();
        r2 = 2'b01;
        settle();
        check("t2_m0_id",    64'(sid2), 64'd0);
        check("t2_m0_stall", 64'(st2),  64'd0);
        check("t2_m0_read",  64'(sr2),  64'd1);
        tick();
        r2 = 2'b00;

        // 1b: m0 asserts several ops at once. All are forwarded, and the payload passes through.
        i2 = 2'b01; ic2 = 2'b01; wd2[31:0] = 32'hDEADBEEF; be2[3:0] = 4'b1010; t2[7:0] = 8'h5A;
        srd2 = 32'hCAFEF00D; sto2 = 8'hA5;
        settle();
        check("t1b_inv",    64'(si2),  64'd1);
        check("t1b_inv_ic", 64'(sic2), 64'd1);
        check("t1b_wrdata", 64'(swd2), 64'hDEADBEEF);
        check("t1b_be",     64'(sbe2), 64'hA);
        check("t1b_trans",  64'(sti2), 64'h5A);
        check("t1b_rddata", 64'(md2),  64'hCAFEF00D);
        check("t1b_tagout", 64'(mt2),  64'hA5);
        tick();
        i2 = 2'b00; ic2 = 2'b00;
        settle();
        check("t1b_rr_ptr", 64'(sid2), 64'd1);

        // 4: while m1 holds the lock, a write raised by m0 mid-stall must wait
        w2 = 2'b10; a2 = {32'h300, 32'h400}; ss2 = 1'b1;
        settle();
        check("t4_id",    64'(sid2), 64'd1);
        check("t4_write", 64'(sw2),  64'd1);
        tick();
        w2 = 2'b11;
        settle();
        check("t4_addr_lock", 64'(sa2), 64'h300);
        check("t4_stall",     64'(st2), 64'd3);
        tick();
        ss2 = 1'b0;
        settle();
        check("t4_addr_done", 64'(sa2), 64'h300);
        check("t4_stall_dn",  64'(st2), 64'd1);
        tick();
        w2 = 2'b01;
        settle();
        check("t4_m0_id",   64'(sid2), 64'd0);
        check("t4_m0_addr", 64'(sa2),  64'h400);
        check("t4_m0_stl",  64'(st2),  64'd0);
        tick();
        w2 = 2'b00;

        // 5: owner m0 drops its request while locked, which aborts the transfer
        r2 = 2'b01; a2[31:0] = 32'h100; ss2 = 1'b1;
        settle();
        check("t5_grant", 64'(sid2), 64'd0);
        tick();
        r2 = 2'b00;
        settle();
        check("t5_drop_read", 64'(sr2),  64'd0);
        check("t5_drop_stl",  64'(st2),  64'd0);
        check("t5_err_early", 64'(err2), 64'd0);
        tick();
        ss2 = 1'b0;
        settle();
        check("t5_err",    64'(err2), 64'd1);
        check("t5_rr_ptr", 64'(sid2), 64'd1);
        tick();
        settle();
        check("t5_err_clr", 64'(err2), 64'd0);

        // 6: an asynchronous reset while locked returns the arbiter to IDLE with rr_ptr=0
        r2 = 2'b10; a2 = {32'h200, 32'h100}; ss2 = 1'b1;
        settle();
        check("t6_grant", 64'(sid2), 64'd1);
        tick();
        r2 = 2'b11;
        settle();
        check("t6_locked", 64'(sid2), 64'd1);
        #2 rst = 1'b1;
        settle();
        check("t6_rst_id",  64'(sid2), 64'd0);
        check("t6_rst_err", 64'(err2), 64'd0);
        tick();
        rst = 1'b0; ss2 = 1'b0;
        settle();
        check("t6_m0_first", 64'(sid2), 64'd0);
        check("t6_m0_stall", 64'(st2),  64'd2);
        tick();
        r2 = 2'b00;

        // 3: with N=3 and all masters requesting, the grant order wraps through 0,1,2,0,1
        r3 = 3'b111;
        for (int c = 0; c < 5; c++) begin
            logic [1:0] exp_id;
            exp_id = 2'(c % 3);
            settle();
            check("t3_id",    64'(sid3), 64'(exp_id));
            check("t3_stall", 64'(st3),  64'(3'b111 & ~(3'b001 << exp_id)));
            tick();
        end
        r3 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
